bbc_host_responder: RTL and testbench



---
 rtl/bbc_bus_pkg.sv | 21 ++
 rtl/phi0_phase_timer.sv | 32 +++
 rtl/bbc_host_responder.sv | 134 +++++++++++++
 tb/tb_bbc_host_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bbc_bus_pkg.sv
// Shared types and helpers for the 6502-socket host bus.
// Used by the host responder and the CPLD-side model.
package bbc_bus_pkg;

  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } phase_e;

  localparam logic [15:0] SLOW_LO_DEF = 16'hFC00;
  localparam logic [15:0] SLOW_HI_DEF = 16'hFEFF;

  function automatic logic bbc_is_slow(
    input logic [15:0] addr,
    input logic [15:0] lo = SLOW_LO_DEF,
    input logic [15:0] hi = SLOW_HI_DEF
  );
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/phi0_phase_timer.sv
// phi0 phase counter: saturating count with a terminal-count flag
// selecting HALF or 3*HALF cycles.
module phi0_phase_timer #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_long,
  output logic o_tc
);

  localparam int W = $clog2(3 * HALF);
  localparam logic [W-1:0] LIM_S = W'(HALF - 1);
  localparam logic [W-1:0] LIM_L = W'(3 * HALF - 1);

  logic [W-1:0] r_cnt;

  // Saturate so long backend stalls cannot wrap the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = r_cnt >= (i_long ? LIM_L : LIM_S);

endmodule

// File: rtl/bbc_host_responder.sv
// BBC host end of the 6502 socket: phi0 generation, bus sampling
// and req/ack forwarding to a backend with clock stretching.
module bbc_host_responder
  import bbc_bus_pkg::*;
#(
  parameter int          HALF    = 4,
  parameter logic [15:0] SLOW_LO = SLOW_LO_DEF,
  parameter logic [15:0] SLOW_HI = SLOW_HI_DEF
) (
  input  logic        hsclk,
  input  logic        resetb,
  output logic        phi0,
  input  logic [15:0] bbc_a,
  input  logic        bbc_rnw,
  input  logic [7:0]  bbc_d_in,
  output logic [7:0]  bbc_d_out,
  output logic        bbc_d_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        slow_cycle
);

  phase_e      r_state;
  phase_e      w_next;
  logic        w_tc;
  logic        w_rise;
  logic        w_fall;
  logic        w_rd_wait;
  logic        w_wr_wait;
  logic        r_req;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_rnw;
  logic [7:0]  r_dout;
  logic        r_oe;
  logic        r_hold;
  logic        r_slow;

  // An ack on this very cycle already satisfies the wait.
  assign w_wr_wait = r_req & r_we & ~mem_ack;
  assign w_rd_wait = r_req & ~r_we & ~mem_ack;

  phi0_phase_timer #(
    .HALF (HALF)
  ) u_timer (
    .clk    (hsclk),
    .rst_n  (resetb),
    .i_clr  (w_rise | w_fall),
    .i_long ((r_state == S_HIGH) & r_slow),
    .o_tc   (w_tc)
  );

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) r_state <= S_LOW;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rise = 1'b0;
    w_fall = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (w_tc && !w_wr_wait) begin
          w_next = S_HIGH;
          w_rise = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_tc && !w_rd_wait) begin
          w_next = S_LOW;
          w_fall = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rnw   <= 1'b1;
      r_dout  <= '0;
      r_oe    <= 1'b0;
      r_hold  <= 1'b0;
      r_slow  <= 1'b0;
    end else begin
      if (r_req && mem_ack) begin
        r_req <= 1'b0;
        if (!r_we) begin
          r_dout <= mem_rdata;
          r_oe   <= 1'b1;
        end
      end
      if (r_hold) begin
        r_oe   <= 1'b0;
        r_hold <= 1'b0;
      end
      if (w_rise) begin
        r_addr <= bbc_a;
        r_rnw  <= bbc_rnw;
        r_slow <= bbc_is_slow(bbc_a, SLOW_LO, SLOW_HI);
        r_we   <= 1'b0;
        if (bbc_rnw) r_req <= 1'b1;
      end
      // Read data is held one hsclk past the falling phi0 edge.
      if (w_fall) begin
        r_hold <= 1'b1;
        if (!r_rnw) begin
          r_wdata <= bbc_d_in;
          r_req   <= 1'b1;
          r_we    <= 1'b1;
        end
      end
    end
  end

  assign phi0       = (r_state == S_HIGH);
  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign bbc_d_out  = r_dout;
  assign bbc_d_oe   = r_oe;
  assign slow_cycle = r_slow;

endmodule

// File: tb/tb_bbc_host_responder.sv
// Directed bench for bbc_host_responder: phase lengths, handshake,
// read data hold, slow region boundaries and async reset.
module tb_bbc_host_responder;

  logic        hsclk = 1'b0;
  logic        resetb;
  logic        phi0;
  logic [15:0] bbc_a;
  logic        bbc_rnw;
  logic [7:0]  bbc_d_in;
  logic [7:0]  bbc_d_out;
  logic        bbc_d_oe;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        slow_cycle;

  int n_chk = 0;
  int n_err = 0;

  always #5 hsclk = ~hsclk;

  bbc_host_responder dut (
    .hsclk      (hsclk),
    .resetb     (resetb),
    .phi0       (phi0),
    .bbc_a      (bbc_a),
    .bbc_rnw    (bbc_rnw),
    .bbc_d_in   (bbc_d_in),
    .bbc_d_out  (bbc_d_out),
    .bbc_d_oe   (bbc_d_oe),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .slow_cycle (slow_cycle)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hsclk);
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      n++;
      if (phi0) break;
    end
  endtask

  task automatic run_hi(input int k, input logic [7:0] rd,
                        output int len, output logic req_pre,
                        output logic req_post, output logic oe_post,
                        output logic [7:0] dout_post);
    len = 0;
    req_pre = 1'b0;
    req_post = 1'b0;
    oe_post = 1'b0;
    dout_post = 8'h00;
    for (int i = 0; i < 64; i++) begin
      mem_ack   = (i == k);
      mem_rdata = (i == k) ? rd : 8'h00;
      if (i == k) req_pre = mem_req;
      tick();
      len++;
      if (i == k) begin
        req_post  = mem_req;
        oe_post   = bbc_d_oe;
        dout_post = bbc_d_out;
      end
      if (!phi0) break;
    end
    mem_ack = 1'b0;
  endtask

  task automatic run_lo(input int k, output int len, output logic oe1);
    len = 0;
    oe1 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_ack   = (i == k);
      mem_rdata = (i == k) ? 8'hEE : 8'h00;
      tick();
      len++;
      if (i == 0) oe1 = bbc_d_oe;
      if (phi0) break;
    end
    mem_ack = 1'b0;
  endtask

  int         n;
  logic       rp, rq, oe, oe1;
  logic [7:0] dv;

  initial begin
    resetb = 1'b0;
    bbc_a = 16'h1234;
    bbc_rnw = 1'b1;
    bbc_d_in = 8'h00;
    mem_rdata = 8'h00;
    mem_ack = 1'b0;
    repeat (3) tick();
    check("rst_phi0", phi0, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_dout", bbc_d_out, 0);
    check("rst_oe", bbc_d_oe, 0);
    check("rst_slow", slow_cycle, 0);

    // Fast read of 1234, ack one cycle after req
    resetb = 1'b1;
    wait_rise(n);
    check("first_rise", n, 4);
    check("rd1_req", mem_req, 1);
    check("rd1_we", mem_we, 0);
    check("rd1_addr", mem_addr, 16'h1234);
    check("rd1_slow", slow_cycle, 0);
    run_hi(1, 8'h5A, n, rp, rq, oe, dv);
    check("rd1_hi", n, 4);
    check("rd1_req_post", rq, 0);
    check("rd1_oe", oe, 1);
    check("rd1_dout", dv, 8'h5A);
    check("rd1_hold_oe", bbc_d_oe, 1);
    check("rd1_hold_dout", bbc_d_out, 8'h5A);
    bbc_a = 16'hFE40;
    run_lo(-1, n, oe1);
    check("rd1_lo", n, 4);
    check("rd1_oe_off", oe1, 0);

    // Slow region and its boundaries
    check("fe40_slow", slow_cycle, 1);
    check("fe40_addr", mem_addr, 16'hFE40);
    run_hi(0, 8'h11, n, rp, rq, oe, dv);
    check("fe40_hi", n, 12);
    bbc_a = 16'hFBFF;
    run_lo(-1, n, oe1);
    check("fe40_lo", n, 4);
    check("fbff_slow", slow_cycle, 0);
    run_hi(0, 8'h22, n, rp, rq, oe, dv);
    check("fbff_hi", n, 4);
    bbc_a = 16'hFF00;
    run_lo(-1, n, oe1);
    check("ff00_slow", slow_cycle, 0);
    run_hi(0, 8'h33, n, rp, rq, oe, dv);
    check("ff00_hi", n, 4);

    // Fast read, ack delayed 10 cycles
    bbc_a = 16'h0100;
    run_lo(-1, n, oe1);
    run_hi(10, 8'hC3, n, rp, rq, oe, dv);
    check("dly_hi", n, 11);
    check("dly_req_pre", rp, 1);
    check("dly_req_post", rq, 0);
    check("dly_dout", dv, 8'hC3);

    // Write A5 to 3000, ack delayed 6
    bbc_a = 16'h3000;
    bbc_rnw = 1'b0;
    run_lo(-1, n, oe1);
    check("wr_req_hi", mem_req, 0);
    bbc_d_in = 8'hA5;
    run_hi(-1, 8'h00, n, rp, rq, oe, dv);
    check("wr_hi", n, 4);
    check("wr_req", mem_req, 1);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 16'h3000);
    check("wr_wdata", mem_wdata, 8'hA5);
    bbc_d_in = 8'h00;
    bbc_a = 16'h3001;
    run_lo(6, n, oe1);
    check("wr_lo6", n, 7);
    check("wr_wdata_hold", mem_wdata, 8'hA5);
    check("wr_req_done", mem_req, 0);
    bbc_d_in = 8'h3C;
    run_hi(-1, 8'h00, n, rp, rq, oe, dv);
    check("wr2_wdata", mem_wdata, 8'h3C);
    bbc_a = 16'h2000;
    bbc_rnw = 1'b1;
    run_lo(3, n, oe1);
    check("wr_lo3", n, 4);

    // Read 2000 then spurious acks in a write cycle
    run_hi(4, 8'h77, n, rp, rq, oe, dv);
    check("rd4_hi", n, 5);
    bbc_a = 16'h4000;
    bbc_rnw = 1'b0;
    run_lo(1, n, oe1);
    check("sp_lo", n, 4);
    check("sp_req", mem_req, 0);
    check("sp_oe", bbc_d_oe, 0);
    check("sp_dout", bbc_d_out, 8'h77);
    run_hi(2, 8'hEE, n, rp, rq, oe, dv);
    check("sp_hi", n, 4);
    check("sp_oe2", oe, 0);
    check("sp_dout2", dv, 8'h77);

    // Reset during a pending read
    bbc_a = 16'h5555;
    bbc_rnw = 1'b1;
    run_lo(0, n, oe1);
    check("pre_rst_lo", n, 4);
    tick();
    tick();
    check("pre_rst_req", mem_req, 1);
    #2;
    resetb = 1'b0;
    #1;
    check("ar_phi0", phi0, 0);
    check("ar_req", mem_req, 0);
    check("ar_oe", bbc_d_oe, 0);
    check("ar_addr", mem_addr, 0);
    tick();
    tick();
    resetb = 1'b1;
    wait_rise(n);
    check("ar_rise", n, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
